// File: rtl/srom_shadow_loader.sv
// srom_shadow_loader
// Boot-time shadow loader. After reset (or a reload pulse) it reads DEPTH words
// of DATA_W bits from an SPI serial ROM using a single READ command followed by
// a continuous MSB-first data stream, and writes them into an external
// asynchronous SRAM at addresses 0..DEPTH-1. Once the copy is complete, ready
// rises and the SRAM is served through a fully pipelined, valid-qualified read
// port: one request per cycle, each answered on the following cycle.
//
// Ports
//   i_clk_srom      system and SROM clock; all logic runs on the rising edge
//   i_rst           asynchronous active-high reset
//   i_reload        one-cycle pulse: abort everything and restart from word 0
//   o_ready         load complete, read port live
//   i_rd_en         read request, honoured only while o_ready=1
//   i_address       read word address, sampled together with i_rd_en
//   o_data          read data, qualified by o_data_valid
//   o_data_valid    one-cycle strobe per accepted read request
//   o_load_count    number of words written during the current load
//   o_srom_cs_n     SROM chip select (active low)
//   o_srom_sck      SROM serial clock (idles low)
//   o_srom_di       serial data towards the SROM
//   i_srom_do       serial data from the SROM
//   o_sram_address  SRAM word address
//   io_sram_dio     SRAM data bus; driven only during writes, otherwise high-Z
//   o_sram_ce_n     SRAM chip enable (active low)
//   o_sram_oe_n     SRAM output enable (active low)
//   o_sram_we_n     SRAM write enable (active low)
module srom_shadow_loader #(
  parameter int unsigned AW         = 15,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH      = 32768,
  parameter int unsigned ADDR_BYTES = 3,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter int unsigned SROM_BASE  = 0
) (
  input  logic              i_clk_srom,
  input  logic              i_rst,
  input  logic              i_reload,
  output logic              o_ready,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic [AW:0]       o_load_count,
  output logic              o_srom_cs_n,
  output logic              o_srom_sck,
  output logic              o_srom_di,
  input  logic              i_srom_do,
  output logic [AW-1:0]     o_sram_address,
  inout  wire  [DATA_W-1:0] io_sram_dio,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n
);

  localparam int unsigned ABW     = 8 * ADDR_BYTES;
  localparam int unsigned TXW     = 8 + ABW;
  localparam int unsigned CNT_MAX = (TXW > DATA_W) ? TXW : DATA_W;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned LCW     = AW + 1;

  // Command opcode followed by the start address, sent as one MSB-first field.
  localparam logic [TXW-1:0] TX_INIT = {READ_CMD, ABW'(SROM_BASE)};

  typedef enum logic [2:0] {
    S_CSH,
    S_CMD,
    S_ADR,
    S_DAT,
    S_WR,
    S_RDY
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_phase;
  logic [TXW-1:0]      r_tx;
  logic [DATA_W-1:0]   r_shift;
  logic [AW:0]         r_load_count;
  logic                r_ready;
  logic                r_cs_n;
  logic                r_sck;
  logic                r_di;
  logic [AW-1:0]       r_sram_address;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic                r_dio_oe;
  logic                r_pend;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;

  logic                w_tx_done;
  logic                w_dat_done;
  logic                w_last_word;

  assign w_tx_done   = (r_cnt == CW'(TXW - 1));
  assign w_dat_done  = (r_cnt == CW'(DATA_W - 1));
  assign w_last_word = (r_load_count == LCW'(DEPTH - 1));

  // The assembled word stays put in the shift register for the whole write,
  // so it doubles as the SRAM write data.
  assign io_sram_dio = r_dio_oe ? r_shift : {DATA_W{1'bz}};

  assign o_ready        = r_ready;
  assign o_data         = r_data;
  assign o_data_valid   = r_valid;
  assign o_load_count   = r_load_count;
  assign o_srom_cs_n    = r_cs_n;
  assign o_srom_sck     = r_sck;
  assign o_srom_di      = r_di;
  assign o_sram_address = r_sram_address;
  assign o_sram_ce_n    = r_ce_n;
  assign o_sram_oe_n    = r_oe_n;
  assign o_sram_we_n    = r_we_n;

  // Main controller. Each serial bit takes two cycles: phase 0 holds sck low
  // with di already updated, phase 1 holds sck high; the edge that ends phase 1
  // drops sck, samples do and advances to the next bit. The word copy loops
  // DAT -> WR -> DAT without re-sending the command, since the SROM keeps
  // streaming as long as chip select stays low. In RDY the read port is a
  // two-stage pipeline: address/strobes on the request edge, capture one edge
  // later, with r_pend remembering that a capture is owed.
  always_ff @(posedge i_clk_srom or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_CSH;
      r_cnt          <= '0;
      r_phase        <= 1'b0;
      r_tx           <= '0;
      r_shift        <= '0;
      r_load_count   <= '0;
      r_ready        <= 1'b0;
      r_cs_n         <= 1'b1;
      r_sck          <= 1'b0;
      r_di           <= 1'b0;
      r_sram_address <= '0;
      r_ce_n         <= 1'b1;
      r_oe_n         <= 1'b1;
      r_we_n         <= 1'b1;
      r_dio_oe       <= 1'b0;
      r_pend         <= 1'b0;
      r_valid        <= 1'b0;
      r_data         <= '0;
    end else if (i_reload) begin
      // Reload beats everything, including a read request on the same edge;
      // any read still in the pipeline is silently dropped.
      r_state      <= S_CSH;
      r_cnt        <= '0;
      r_phase      <= 1'b0;
      r_load_count <= '0;
      r_ready      <= 1'b0;
      r_cs_n       <= 1'b1;
      r_sck        <= 1'b0;
      r_di         <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_dio_oe     <= 1'b0;
      r_pend       <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_pend  <= 1'b0;
      case (r_state)
        S_CSH: begin
          if (r_cnt == CW'(1)) begin
            r_cs_n  <= 1'b0;
            r_state <= S_CMD;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_tx    <= TX_INIT;
            r_di    <= TX_INIT[TXW-1];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_CMD, S_ADR: begin
          if (!r_phase) begin
            r_sck   <= 1'b1;
            r_phase <= 1'b1;
          end else begin
            r_sck   <= 1'b0;
            r_phase <= 1'b0;
            r_tx    <= r_tx << 1;
            if (w_tx_done) begin
              r_state <= S_DAT;
              r_di    <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_di  <= r_tx[TXW-2];
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == CW'(7)) begin
                r_state <= S_ADR;
              end
            end
          end
        end

        S_DAT: begin
          if (!r_phase) begin
            r_sck   <= 1'b1;
            r_phase <= 1'b1;
          end else begin
            r_sck   <= 1'b0;
            r_phase <= 1'b0;
            r_shift <= {r_shift[DATA_W-2:0], i_srom_do};
            if (w_dat_done) begin
              r_state        <= S_WR;
              r_cnt          <= '0;
              r_sram_address <= r_load_count[AW-1:0];
              r_ce_n         <= 1'b0;
              r_we_n         <= 1'b1;
              r_dio_oe       <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        // Three-cycle write: setup, we_n pulse, hold. Data and address stay
        // stable across the rising edge of we_n where the SRAM latches.
        S_WR: begin
          if (r_cnt == '0) begin
            r_we_n <= 1'b0;
            r_cnt  <= CW'(1);
          end else if (r_cnt == CW'(1)) begin
            r_we_n <= 1'b1;
            r_cnt  <= CW'(2);
          end else begin
            r_load_count <= r_load_count + 1'b1;
            r_dio_oe     <= 1'b0;
            r_ce_n       <= 1'b1;
            r_cnt        <= '0;
            if (w_last_word) begin
              r_state <= S_RDY;
              r_cs_n  <= 1'b1;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_DAT;
            end
          end
        end

        S_RDY: begin
          r_pend <= i_rd_en;
          r_ce_n <= ~i_rd_en;
          r_oe_n <= ~i_rd_en;
          if (i_rd_en) begin
            r_sram_address <= i_address;
          end
          if (r_pend) begin
            r_data  <= io_sram_dio;
            r_valid <= 1'b1;
          end
        end

        default: begin
          r_state <= S_CSH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srom_shadow_loader.sv
// tb_srom_shadow_loader
// Self-checking bench for srom_shadow_loader with a 4-word, 16-bit image.
// Contains a behavioural SPI serial ROM (records the command/address bits it
// receives and streams a word list), a behavioural asynchronous SRAM, and a
// protocol monitor. Expected read data comes from a reference copy of the
// word list that a complete load should leave in the SRAM.
module tb_srom_shadow_loader;

  localparam int AW          = 4;
  localparam int DW          = 16;
  localparam int DEPTH       = 4;
  localparam int AB          = 3;
  localparam int HDR_BITS    = 8 + 8 * AB;
  localparam int LOAD_CYCLES = 2 + 2 * HDR_BITS + DEPTH * (2 * DW + 3);
  localparam int BUDGET      = 2000;

  logic clock = 1'b0;
  logic reset;
  logic reload;
  logic rdEn;
  logic [AW-1:0] address;
  logic ready;
  logic [DW-1:0] dataOut;
  logic dataValid;
  logic [AW:0] loadCount;
  logic sromCsN;
  logic sromSck;
  logic sromDi;
  logic sromDo = 1'b0;
  logic [AW-1:0] sramAddress;
  wire  [DW-1:0] sramDio;
  logic sramCeN;
  logic sramOeN;
  logic sramWeN;

  int checks = 0;
  int errors = 0;
  int protoViol = 0;

  logic [DW-1:0] streamWords [DEPTH];
  logic [DW-1:0] refMem [DEPTH];
  logic [DW-1:0] sramMem [16];

  int riseCount = 0;
  int bitIdx = 0;
  int wordIdx = 0;
  logic [31:0] cmdShift = '0;

  srom_shadow_loader #(
    .AW(AW), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_BYTES(AB),
    .READ_CMD(8'h03), .SROM_BASE(0)
  ) dut (
    .i_clk_srom(clock),
    .i_rst(reset),
    .i_reload(reload),
    .o_ready(ready),
    .i_rd_en(rdEn),
    .i_address(address),
    .o_data(dataOut),
    .o_data_valid(dataValid),
    .o_load_count(loadCount),
    .o_srom_cs_n(sromCsN),
    .o_srom_sck(sromSck),
    .o_srom_di(sromDi),
    .i_srom_do(sromDo),
    .o_sram_address(sramAddress),
    .io_sram_dio(sramDio),
    .o_sram_ce_n(sramCeN),
    .o_sram_oe_n(sramOeN),
    .o_sram_we_n(sramWeN)
  );

  always #5 clock = ~clock;

  // Serial ROM model. A falling chip select starts a new transaction. The first
  // HDR_BITS rising sck edges clock in command and address; after that every
  // rising edge presents the next stream bit, held through the high phase.
  always @(posedge sromSck or negedge sromCsN) begin
    if (!sromSck) begin
      riseCount = 0;
      cmdShift  = '0;
      sromDo    = 1'b0;
    end else if (!sromCsN) begin
      riseCount++;
      if (riseCount <= HDR_BITS) begin
        cmdShift = {cmdShift[30:0], sromDi};
      end else begin
        bitIdx  = riseCount - HDR_BITS - 1;
        wordIdx = bitIdx / DW;
        if (wordIdx < DEPTH) sromDo = streamWords[wordIdx][DW-1-(bitIdx % DW)];
        else sromDo = 1'b0;
      end
    end
  end

  // Asynchronous SRAM model: outputs while selected and output-enabled,
  // latches the bus on the rising edge of we_n.
  assign sramDio = (!sramCeN && !sramOeN && sramWeN) ? sramMem[sramAddress] : {DW{1'bz}};

  always @(posedge sramWeN) begin
    if (!reset && sramCeN == 1'b0) sramMem[sramAddress] = sramDio;
  end

  // Whole-run protocol watch: sck only high inside a transaction, never a
  // write strobe together with output enable, and during reads the bus must
  // carry exactly what the SRAM drives (any loader drive would corrupt it).
  always @(negedge clock) begin
    if (sromSck && sromCsN) protoViol++;
    if (!sramWeN && !sramOeN) protoViol++;
    if (!sramOeN && sramDio !== sramMem[sramAddress]) protoViol++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [AW-1:0] a);
    rdEn    = en;
    address = a;
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (ready !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
  endtask

  task automatic newStream();
    for (int i = 0; i < DEPTH; i++) streamWords[i] = DW'($urandom);
  endtask

  task automatic checkImage(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput(tag, sramMem[i], streamWords[i]);
      refMem[i] = streamWords[i];
    end
  endtask

  // Issue n read cycles (directed: addresses 0..n-1 back to back; otherwise
  // random enable/address), then two idle cycles to drain the pipeline.
  task automatic runReads(input int n, input bit directed);
    logic prevAcc;
    logic [AW-1:0] prevAddr;
    logic en;
    logic [AW-1:0] a;
    prevAcc  = 1'b0;
    prevAddr = '0;
    for (int k = 0; k < n + 2; k++) begin
      if (k < n) begin
        if (directed) begin
          en = 1'b1;
          a  = AW'(k);
        end else begin
          en = 1'($urandom_range(0, 1));
          a  = AW'($urandom_range(0, DEPTH - 1));
        end
      end else begin
        en = 1'b0;
        a  = '0;
      end
      applyStimulus(en, a);
      tick();
      checkOutput("rd_valid", dataValid, prevAcc);
      if (prevAcc) checkOutput("rd_data", dataOut, refMem[prevAddr]);
      checkOutput("rd_oe_n", sramOeN, !en);
      prevAcc  = en;
      prevAddr = a;
    end
  endtask

  initial begin
    int n;
    int readyAt;
    int firstValid;
    int earlyValid;
    int lateValid;
    logic [DW-1:0] firstData;

    reset  = 1'b1;
    reload = 1'b0;
    applyStimulus(1'b0, '0);
    #1;
    for (int i = 0; i < 16; i++) sramMem[i] = '0;
    for (int i = 0; i < DEPTH; i++) streamWords[i] = DW'(16'h1001 + i);

    // Boot from reset with the fixed 0x1001..0x1004 image
    repeat (2) tick();
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_valid", dataValid, 0);
    checkOutput("rst_data", dataOut, 0);
    checkOutput("rst_load_count", loadCount, 0);
    checkOutput("rst_cs_n", sromCsN, 1);
    checkOutput("rst_sck", sromSck, 0);
    checkOutput("rst_di", sromDi, 0);
    checkOutput("rst_ce_n", sramCeN, 1);
    checkOutput("rst_oe_n", sramOeN, 1);
    checkOutput("rst_we_n", sramWeN, 1);
    checkOutput("rst_sram_addr", sramAddress, 0);
    reset = 1'b0;
    waitReady(n);
    checkOutput("boot_latency", n, LOAD_CYCLES);
    checkOutput("boot_cmd", cmdShift, 32'h0300_0000);
    checkOutput("boot_sck_rises", riseCount, HDR_BITS + DEPTH * DW);
    checkOutput("boot_load_count", loadCount, DEPTH);
    checkOutput("boot_cs_n", sromCsN, 1);
    checkImage("boot_sram");

    // Back-to-back reads of every word, then a random read mix
    runReads(DEPTH, 1'b1);
    runReads(40, 1'b0);

    // Reads requested continuously from reset release
    newStream();
    reset = 1'b1;
    tick();
    applyStimulus(1'b1, '0);
    reset      = 1'b0;
    readyAt    = -1;
    firstValid = -1;
    earlyValid = 0;
    firstData  = '0;
    for (int c = 1; c <= BUDGET; c++) begin
      tick();
      if (dataValid && readyAt < 0) earlyValid++;
      if (dataValid && readyAt >= 0 && firstValid < 0) begin
        firstValid = c;
        firstData  = dataOut;
      end
      if (ready && readyAt < 0) readyAt = c;
      if (firstValid >= 0) break;
    end
    applyStimulus(1'b0, '0);
    checkOutput("early_no_valid", earlyValid, 0);
    checkOutput("early_ready_at", readyAt, LOAD_CYCLES);
    checkOutput("early_first_valid", firstValid, LOAD_CYCLES + 2);
    checkOutput("early_first_data", firstData, streamWords[0]);
    tick();
    checkImage("early_sram");

    // Reload while word 2 is being shifted in
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (loadCount != 2 && n < BUDGET) begin
      tick();
      n++;
    end
    checkOutput("mid_count", loadCount, 2);
    repeat (10) tick();
    checkOutput("mid_pre_cs_n", sromCsN, 0);
    newStream();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    checkOutput("reload_cs_n0", sromCsN, 1);
    checkOutput("reload_load_count", loadCount, 0);
    checkOutput("reload_ready", ready, 0);
    checkOutput("reload_sck", sromSck, 0);
    checkOutput("reload_we_n", sramWeN, 1);
    tick();
    checkOutput("reload_cs_n1", sromCsN, 1);
    tick();
    checkOutput("reload_cs_low", sromCsN, 0);
    waitReady(n);
    checkOutput("reload_latency", n + 2, LOAD_CYCLES);
    checkOutput("reload_cmd", cmdShift, 32'h0300_0000);
    checkImage("reload_sram");
    runReads(DEPTH, 1'b1);

    // Reload on the cycle after a read request, with another request pending
    applyStimulus(1'b1, AW'(2));
    tick();
    checkOutput("inflight_oe_n", sramOeN, 0);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("inflight_valid", dataValid, 0);
    checkOutput("inflight_ready", ready, 0);
    checkOutput("inflight_oe_n_off", sramOeN, 1);
    checkOutput("inflight_ce_n_off", sramCeN, 1);
    lateValid = 0;
    repeat (4) begin
      tick();
      if (dataValid) lateValid++;
    end
    checkOutput("inflight_late_valid", lateValid, 0);

    // Asynchronous reset in the middle of a transaction
    repeat (20) tick();
    checkOutput("arst_pre_cs_n", sromCsN, 0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst_ready", ready, 0);
    checkOutput("arst_cs_n", sromCsN, 1);
    checkOutput("arst_sck", sromSck, 0);
    checkOutput("arst_di", sromDi, 0);
    checkOutput("arst_we_n", sramWeN, 1);
    checkOutput("arst_ce_n", sramCeN, 1);
    checkOutput("arst_load_count", loadCount, 0);
    tick();
    reset = 1'b0;
    waitReady(n);
    checkOutput("arst_latency", n, LOAD_CYCLES);
    checkImage("arst_sram");
    runReads(30, 1'b0);

    checkOutput("protocol", protoViol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
